// File: rtl/fpu_wb_sequencer.sv
// fpu_wb_sequencer
// Wishbone-slave command sequencer for the single-precision FPU datapath.
// Firmware loads operands and an opcode, then sets CTRL.start. The block
// pulses the FPU unit reset and waits for done, or for a timeout on adds.
// It then captures the result and flags and can raise a level interrupt.
// Wishbone transfers are classic single-cycle-ack: ack rises one cycle
// after the request is seen. The transfer commits on the following edge,
// where the master samples ack high.
module fpu_wb_sequencer #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          TIMEOUT  = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [2:0]  fpu_opcode,
    output logic        fpu_rst_n,
    input  logic [31:0] fpu_result,
    input  logic [8:0]  fpu_flags,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        CAPT = 2'd3
    } state_t;

    localparam logic [2:0] OPC_ADD  = 3'd0;
    localparam logic [2:0] OPC_CMP  = 3'd4;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    // Merge write data into a register under the Wishbone byte enables
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = sel[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic        irq_en_q;
    logic        done_q, timeout_q, bad_op_q, wr_busy_q;
    logic [31:0] result_q;
    logic [8:0]  flags_q;
    logic [31:0] rdata;

    logic hit_opa, hit_opb, hit_ctrl, hit_stat, hit_res;
    logic bus_req, rd_phase, wr_commit;
    logic busy, wr_cfg, busy_wr, cfg_wr_ok, w1c_stat;
    logic start_req, op_ok, start_go, start_bad;
    logic capture, time_out;

    // Exact word decode; anything else reads 0 and ignores writes.
    assign hit_opa  = (wbs_adr_i == BASE_ADR);
    assign hit_opb  = (wbs_adr_i == BASE_ADR + 32'h04);
    assign hit_ctrl = (wbs_adr_i == BASE_ADR + 32'h08);
    assign hit_stat = (wbs_adr_i == BASE_ADR + 32'h0C);
    assign hit_res  = (wbs_adr_i == BASE_ADR + 32'h10);

    assign bus_req   = wbs_stb_i & wbs_cyc_i;
    assign rd_phase  = bus_req & ~wbs_ack_o & ~wbs_we_i;
    assign wr_commit = bus_req & wbs_ack_o & wbs_we_i;

    assign busy      = (state_q != IDLE);
    assign wr_cfg    = wr_commit & (hit_opa | hit_opb | hit_ctrl);
    assign busy_wr   = wr_cfg & busy;
    assign cfg_wr_ok = wr_cfg & ~busy;
    assign w1c_stat  = wr_commit & hit_stat;

    // The opcode checked at start is the one written alongside the start bit.
    assign start_req = cfg_wr_ok & hit_ctrl & wbs_dat_i[8];
    assign op_ok     = (wbs_dat_i[2:0] == OPC_ADD) || (wbs_dat_i[2:0] == OPC_CMP);
    assign start_go  = start_req & op_ok;
    assign start_bad = start_req & ~op_ok;

    assign irq_o = irq_en_q & (done_q | timeout_q | bad_op_q);

    // Wishbone ack: one registered pulse per request, never back-to-back
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
        end else begin
            wbs_ack_o <= bus_req & ~wbs_ack_o;
        end
    end

    // Register read mux
    always_comb begin
        rdata = 32'h0;
        if (hit_opa) begin
            rdata = fpu_a;
        end else if (hit_opb) begin
            rdata = fpu_b;
        end else if (hit_ctrl) begin
            rdata = {22'h0, irq_en_q, 1'b0, 5'h0, fpu_opcode};
        end else if (hit_stat) begin
            rdata = {15'h0, flags_q, 3'h0, wr_busy_q, bad_op_q, timeout_q, done_q, busy};
        end else if (hit_res) begin
            rdata = result_q;
        end
    end

    // Read data is loaded as ack rises so it is valid while ack is high
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_dat_o <= 32'h0;
        end else begin
            wbs_dat_o <= rd_phase ? rdata : 32'h0;
        end
    end

    // FSM state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state plus capture / timeout strobes
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        time_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_go) begin
                    state_d = CLR;
                end
            end
            CLR: begin
                state_d = RUN;
            end
            RUN: begin
                // Compare is combinational in the FPU, so one RUN cycle suffices.
                if (fpu_opcode == OPC_CMP) begin
                    state_d = CAPT;
                end else if (fpu_flags[8]) begin
                    state_d = CAPT;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE;
                    time_out = 1'b1;
                end
            end
            CAPT: begin
                state_d = IDLE;
                capture = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RUN cycle counter, zeroed while the FPU is held in reset
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_q <= 8'h0;
        end else if (state_q == CLR) begin
            cnt_q <= 8'h0;
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + 8'h1;
        end
    end

    // FPU unit reset: low under block reset and for the single CLR cycle
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            fpu_rst_n <= 1'b0;
        end else begin
            fpu_rst_n <= (state_d != CLR);
        end
    end

    // Configuration registers; writes while busy are dropped
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            fpu_a      <= 32'h0;
            fpu_b      <= 32'h0;
            fpu_opcode <= 3'h0;
            irq_en_q   <= 1'b0;
        end else if (cfg_wr_ok) begin
            if (hit_opa) begin
                fpu_a <= merge_bytes(fpu_a, wbs_dat_i, wbs_sel_i);
            end
            if (hit_opb) begin
                fpu_b <= merge_bytes(fpu_b, wbs_dat_i, wbs_sel_i);
            end
            if (hit_ctrl) begin
                fpu_opcode <= wbs_dat_i[2:0];
                irq_en_q   <= wbs_dat_i[9];
            end
        end
    end

    // Sticky status bits; hardware set takes priority over firmware clear
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            bad_op_q  <= 1'b0;
            wr_busy_q <= 1'b0;
        end else begin
            if (capture) begin
                done_q <= 1'b1;
            end else if (start_go || (w1c_stat && wbs_dat_i[1])) begin
                done_q <= 1'b0;
            end
            if (time_out) begin
                timeout_q <= 1'b1;
            end else if (start_go || (w1c_stat && wbs_dat_i[2])) begin
                timeout_q <= 1'b0;
            end
            if (start_bad) begin
                bad_op_q <= 1'b1;
            end else if (w1c_stat && wbs_dat_i[3]) begin
                bad_op_q <= 1'b0;
            end
            if (busy_wr) begin
                wr_busy_q <= 1'b1;
            end else if (w1c_stat && wbs_dat_i[4]) begin
                wr_busy_q <= 1'b0;
            end
        end
    end

    // Result and flag capture; a timeout leaves both zeroed
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            result_q <= 32'h0;
            flags_q  <= 9'h0;
        end else if (capture) begin
            result_q <= fpu_result;
            flags_q  <= {1'b1, fpu_flags[7:0]};
        end else if (time_out) begin
            result_q <= 32'h0;
            flags_q  <= 9'h0;
        end
    end

endmodule

// File: tb/tb_fpu_wb_sequencer.sv
// Directed bench for fpu_wb_sequencer with a tiny FPU stand-in model.
module tb_fpu_wb_sequencer;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_OPA  = BASE + 32'h00;
    localparam logic [31:0] A_OPB  = BASE + 32'h04;
    localparam logic [31:0] A_CTRL = BASE + 32'h08;
    localparam logic [31:0] A_STAT = BASE + 32'h0C;
    localparam logic [31:0] A_RES  = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic [31:0] fpu_a, fpu_b;
    logic [2:0]  fpu_opcode;
    logic        fpu_rst_n;
    logic [31:0] fpu_result = 32'h0;
    logic [8:0]  fpu_flags;
    logic        irq;

    logic        model_done_en = 1'b0;
    logic        model_eq = 1'b0;
    logic [7:0]  run_cnt = 8'h0;
    int          clr_pulses = 0;

    int checks = 0;
    int errors = 0;

    fpu_wb_sequencer #(.BASE_ADR(BASE), .TIMEOUT(8)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .fpu_a     (fpu_a),
        .fpu_b     (fpu_b),
        .fpu_opcode(fpu_opcode),
        .fpu_rst_n (fpu_rst_n),
        .fpu_result(fpu_result),
        .fpu_flags (fpu_flags),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    // FPU stand-in: cycles since its reset released; done after 5 RUN cycles
    always @(posedge clk) begin
        if (!fpu_rst_n) run_cnt <= 8'h0;
        else if (run_cnt != 8'hFF) run_cnt <= run_cnt + 8'h1;
        if (rst_n && !fpu_rst_n) clr_pulses <= clr_pulses + 1;
    end

    assign fpu_flags = {model_done_en && (run_cnt >= 8'd5), 4'b0, model_eq, 3'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
        int n;
        @(negedge clk);
        adr = a; wdat = d; sel = s; we = w; stb = 1'b1; cyc = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack && n < 16);
        check("wb_ack", {31'b0, ack}, 32'h1);
        rd = rdat;
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, s, dummy);
    endtask

    task automatic wb_read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(1'b0, a, 32'h0, 4'hF, rd);
        check(tag, rd, exp);
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!irq && n < 100);
    endtask

    initial begin
        int n;
        int p0;

        // Reset state
        #3 rst_n = 1'b0;
        #20;
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_fpu_rst_n", {31'b0, fpu_rst_n}, 32'h0);
        check("rst_fpu_a", fpu_a, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rel_fpu_rst_n", {31'b0, fpu_rst_n}, 32'h1);
        wb_read_check("rel_status", A_STAT, 32'h0);

        // Byte-masked operand write
        wb_write(A_OPA, 32'hAABBCCDD, 4'b0101);
        wb_read_check("bytemask_opa", A_OPA, 32'h00BB00DD);
        check("bytemask_fpu_a", fpu_a, 32'h00BB00DD);

        // Add: 1.0 + 2.0, done 5 cycles into RUN
        wb_write(A_OPA, 32'h3F800000, 4'hF);
        wb_write(A_OPB, 32'h40000000, 4'hF);
        check("fpu_a", fpu_a, 32'h3F800000);
        check("fpu_b", fpu_b, 32'h40000000);
        model_done_en = 1'b1;
        fpu_result = 32'h40400000;
        p0 = clr_pulses;
        wb_write(A_CTRL, 32'h300, 4'hF);
        wait_irq(n);
        check("add_latency", n, 8);
        check("add_clr_pulse", clr_pulses - p0, 1);
        wb_read_check("add_result", A_RES, 32'h40400000);
        wb_read_check("add_status", A_STAT, 32'h00010002);
        wb_read_check("ctrl_read", A_CTRL, 32'h200);

        // W1C done drops irq, flags stay
        wb_write(A_STAT, 32'h2, 4'hF);
        check("w1c_done_irq", {31'b0, irq}, 32'h0);
        wb_read_check("w1c_done_status", A_STAT, 32'h00010000);

        // Compare: done input held low, eq set
        model_done_en = 1'b0;
        model_eq = 1'b1;
        fpu_result = 32'h00000001;
        wb_write(A_CTRL, 32'h304, 4'hF);
        check("cmp_opcode", {29'b0, fpu_opcode}, 32'h4);
        wait_irq(n);
        check("cmp_latency", n, 3);
        wb_read_check("cmp_status", A_STAT, 32'h00010802);
        wb_read_check("cmp_result", A_RES, 32'h00000001);

        // Timeout on add with done never arriving
        model_eq = 1'b0;
        fpu_result = 32'hDEADBEEF;
        wb_write(A_CTRL, 32'h300, 4'hF);
        wait_irq(n);
        check("tmo_latency", n, 9);
        wb_read_check("tmo_status", A_STAT, 32'h00000004);
        wb_read_check("tmo_result", A_RES, 32'h0);
        wb_write(A_STAT, 32'h4, 4'hF);
        check("tmo_w1c_irq", {31'b0, irq}, 32'h0);
        wb_read_check("tmo_w1c_status", A_STAT, 32'h0);

        // Busy write is discarded and flagged
        wb_write(A_CTRL, 32'h300, 4'hF);
        wb_write(A_OPA, 32'h12345678, 4'hF);
        wb_read_check("busy_status", A_STAT, 32'h00000011);
        wait_irq(n);
        check("busy_irq", {31'b0, irq}, 32'h1);
        wb_read_check("busy_opa", A_OPA, 32'h3F800000);
        wb_read_check("busy_status_end", A_STAT, 32'h00000014);
        wb_write(A_STAT, 32'h14, 4'hF);

        // Bad opcode: no FPU reset pulse, bad_op raised
        p0 = clr_pulses;
        wb_write(A_CTRL, 32'h302, 4'hF);
        repeat (6) @(posedge clk);
        #1;
        check("badop_no_pulse", clr_pulses - p0, 0);
        check("badop_irq", {31'b0, irq}, 32'h1);
        wb_read_check("badop_status", A_STAT, 32'h00000008);
        wb_write(A_STAT, 32'h8, 4'hF);
        check("badop_w1c_irq", {31'b0, irq}, 32'h0);

        // Unmapped offsets read 0 and ignore writes
        wb_write(BASE + 32'h14, 32'hFFFFFFFF, 4'hF);
        wb_read_check("unmapped_read", BASE + 32'h14, 32'h0);
        wb_read_check("unmapped_opa", A_OPA, 32'h3F800000);

        // Reset in the middle of RUN
        wb_write(A_CTRL, 32'h300, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_fpu_a", fpu_a, 32'h0);
        check("midrst_fpu_b", fpu_b, 32'h0);
        check("midrst_opcode", {29'b0, fpu_opcode}, 32'h0);
        check("midrst_fpu_rst_n", {31'b0, fpu_rst_n}, 32'h0);
        check("midrst_irq_ack", {30'b0, irq, ack}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_rel_fpu_rst_n", {31'b0, fpu_rst_n}, 32'h1);
        wb_read_check("midrst_status", A_STAT, 32'h0);
        wb_read_check("midrst_result", A_RES, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
